// File: rtl/wb_pkg.sv
// Shared encodings and sizing helpers for the Wishbone address decoder.
// Pure declarations: no logic, no latency, no flow control.
package wb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] UNMAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_ACTIVE = ACTIVE,
    S_UNMAP  = UNMAP
  } wb_state_e;

  localparam logic [31:0] DEF_UNMAPPED_DATA = 32'hDEADBEEF;
  localparam int          DEF_SW            = 32 / 8;

  function automatic int sel_width(input int dw);
    return dw / 8;
  endfunction

  // A disabled watchdog still gets a 1-bit width so declarations stay legal.
  function automatic int wdog_width(input int timeout);
    return (timeout <= 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Per-transfer cycle counter; expire_o asserts combinationally on the TIMEOUT-th enabled cycle.
// Latency: expiry is seen in the same cycle as the final enabled count; no backpressure.
// TIMEOUT=0 removes the counter entirely and expire_o is tied low.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  if (TIMEOUT > 0) begin : g_cnt
    localparam int CW = wdog_width(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (en_i) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // cnt_q holds the number of silent cycles already elapsed before this one.
    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
  end else begin : g_off
    assign expire_o = 1'b0;
  end

endmodule

// File: rtl/wb_decoder_n.sv
// Single-master Wishbone classic decoder: routes to one of NSLAVES by top address bits.
// Latency: 1 cycle decode in IDLE, then slave response passes through combinationally.
// Backpressure: master waits on ack/err; hung slaves are cut off by the watchdog.
module wb_decoder_n
  import wb_pkg::*;
#(
  parameter int                      AW            = 30,
  parameter int                      DW            = 32,
  parameter int                      NSLAVES       = 4,
  parameter int                      MUXW          = 4,
  parameter logic [NSLAVES*MUXW-1:0] SLAVE_IDS     = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter int                      TIMEOUT       = 255,
  parameter bit                      UNMAPPED_ACK  = 1'b0,
  parameter logic [DW-1:0]           UNMAPPED_DATA = DW'(DEF_UNMAPPED_DATA)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_reset_ni,
  input  logic [AW-1:0]         wb_adr_i,
  input  logic [DW-1:0]         wb_dat_i,
  output logic [DW-1:0]         wb_dat_o,
  input  logic                  wb_we_i,
  input  logic [DW/8-1:0]       wb_sel_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [AW-1:0]         wbs_adr_o,
  output logic [DW-1:0]         wbs_dat_o,
  output logic                  wbs_we_o,
  output logic [DW/8-1:0]       wbs_sel_o,
  output logic [NSLAVES-1:0]    wbs_cyc_o,
  output logic [NSLAVES-1:0]    wbs_stb_o,
  input  logic [NSLAVES*DW-1:0] wbs_dat_i,
  input  logic [NSLAVES-1:0]    wbs_ack_i,
  input  logic [NSLAVES-1:0]    wbs_err_i
);

  localparam int SW = sel_width(DW);
  localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  wb_state_e     state_q, state_d;
  logic [IW-1:0] slv_q, slv_d;

  logic          req;
  logic          hit;
  logic [IW-1:0] dec_idx;
  logic          is_active;
  logic          slv_ack;
  logic          slv_err;
  logic          wdog_en;
  logic          wdog_exp;

  assign wbs_adr_o = wb_adr_i;
  assign wbs_dat_o = wb_dat_i;
  assign wbs_we_o  = wb_we_i;
  assign wbs_sel_o = wb_sel_i[SW-1:0];

  assign req = wb_cyc_i & wb_stb_i;

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    dec_idx = '0;
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      if (wb_adr_i[AW-1 -: MUXW] == SLAVE_IDS[k*MUXW +: MUXW]) begin
        hit     = 1'b1;
        dec_idx = IW'(k);
      end
    end
  end

  assign is_active = (state_q == S_ACTIVE);
  assign slv_ack   = is_active & wbs_ack_i[slv_q] & req;
  assign slv_err   = is_active & wbs_err_i[slv_q] & req & ~wbs_ack_i[slv_q];
  assign wdog_en   = is_active & wb_cyc_i & ~slv_ack & ~slv_err;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (wb_clk_i),
    .rst_n    (wb_reset_ni),
    .clr_i    (~is_active),
    .en_i     (wdog_en),
    .expire_o (wdog_exp)
  );

  always_comb begin
    state_d   = state_q;
    slv_d     = slv_q;
    wb_ack_o  = 1'b0;
    wb_err_o  = 1'b0;
    wb_dat_o  = UNMAPPED_DATA;
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            slv_d   = dec_idx;
            state_d = S_ACTIVE;
          end else begin
            state_d = S_UNMAP;
          end
        end
      end
      S_ACTIVE: begin
        wbs_cyc_o[slv_q] = wb_cyc_i & ~wdog_exp;
        wbs_stb_o[slv_q] = wb_stb_i;
        wb_dat_o         = wbs_dat_i[slv_q*DW +: DW];
        wb_ack_o         = slv_ack;
        wb_err_o         = slv_err | wdog_exp;
        if (!wb_cyc_i || slv_ack || slv_err || wdog_exp) begin
          state_d = S_IDLE;
        end
      end
      S_UNMAP: begin
        wb_ack_o = wb_cyc_i & UNMAPPED_ACK;
        wb_err_o = wb_cyc_i & ~UNMAPPED_ACK;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state_q <= S_IDLE;
      slv_q   <= '0;
    end else begin
      state_q <= state_d;
      slv_q   <= slv_d;
    end
  end

endmodule

// File: tb/tb_wb_decoder_n.sv
// Directed bench for wb_decoder_n: one instance erroring on unmapped (TIMEOUT=8),
// one acking on unmapped with the watchdog disabled, sharing all master/slave inputs.
module tb_wb_decoder_n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [29:0]  m_adr;
  logic [31:0]  m_dat;
  logic         m_we;
  logic [3:0]   m_sel;
  logic         m_cyc;
  logic         m_stb;
  logic [127:0] s_dat;
  logic [3:0]   s_ack;
  logic [3:0]   s_err;

  logic [31:0]  dat_o,  a_dat_o;
  logic         ack_o,  a_ack_o;
  logic         err_o,  a_err_o;
  logic [29:0]  sadr_o, a_sadr_o;
  logic [31:0]  sdat_o, a_sdat_o;
  logic         swe_o,  a_swe_o;
  logic [3:0]   ssel_o, a_ssel_o;
  logic [3:0]   cyc_o,  a_cyc_o;
  logic [3:0]   stb_o,  a_stb_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_decoder_n #(.TIMEOUT(8), .UNMAPPED_ACK(1'b0)) dut (
    .wb_clk_i (clk),    .wb_reset_ni (rst_n),
    .wb_adr_i (m_adr),  .wb_dat_i (m_dat),   .wb_dat_o (dat_o),
    .wb_we_i  (m_we),   .wb_sel_i (m_sel),
    .wb_cyc_i (m_cyc),  .wb_stb_i (m_stb),
    .wb_ack_o (ack_o),  .wb_err_o (err_o),
    .wbs_adr_o (sadr_o), .wbs_dat_o (sdat_o), .wbs_we_o (swe_o), .wbs_sel_o (ssel_o),
    .wbs_cyc_o (cyc_o),  .wbs_stb_o (stb_o),
    .wbs_dat_i (s_dat),  .wbs_ack_i (s_ack),  .wbs_err_i (s_err)
  );

  wb_decoder_n #(.TIMEOUT(0), .UNMAPPED_ACK(1'b1)) dut_a (
    .wb_clk_i (clk),    .wb_reset_ni (rst_n),
    .wb_adr_i (m_adr),  .wb_dat_i (m_dat),   .wb_dat_o (a_dat_o),
    .wb_we_i  (m_we),   .wb_sel_i (m_sel),
    .wb_cyc_i (m_cyc),  .wb_stb_i (m_stb),
    .wb_ack_o (a_ack_o), .wb_err_o (a_err_o),
    .wbs_adr_o (a_sadr_o), .wbs_dat_o (a_sdat_o), .wbs_we_o (a_swe_o), .wbs_sel_o (a_ssel_o),
    .wbs_cyc_o (a_cyc_o),  .wbs_stb_o (a_stb_o),
    .wbs_dat_i (s_dat),  .wbs_ack_i (s_ack),  .wbs_err_i (s_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [29:0] a, input logic we, input logic [3:0] sel,
                     input logic [31:0] d);
    m_adr = a;
    m_we  = we;
    m_sel = sel;
    m_dat = d;
    m_cyc = 1'b1;
    m_stb = 1'b1;
  endtask

  task automatic drop();
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
    s_ack = '0;
    s_err = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    m_adr = '0;
    m_dat = '0;
    m_sel = '0;
    drop();
    s_dat = {32'h33333333, 32'h22222222, 32'h12345678, 32'h11110000};

    // Reset state
    #3;
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_cyc", {28'd0, cyc_o}, 32'd0);
    check("rst_stb", {28'd0, stb_o}, 32'd0);
    check("rst_dat", dat_o, 32'hDEADBEEF);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Read id 1; slave acks two cycles after its cyc rises
    tick();
    req(30'h0400_0004, 1'b0, 4'hF, 32'h0);
    #1;
    check("rd_idle_cyc", {28'd0, cyc_o}, 32'd0);
    check("rd_idle_ack", {31'd0, ack_o}, 32'd0);
    tick(); #1;
    check("rd_a1_cyc", {28'd0, cyc_o}, 32'h2);
    check("rd_a1_stb", {28'd0, stb_o}, 32'h2);
    check("rd_a1_ack", {31'd0, ack_o}, 32'd0);
    tick(); #1;
    check("rd_a2_ack", {31'd0, ack_o}, 32'd0);
    tick();
    s_ack[1] = 1'b1;
    #1;
    check("rd_ack", {31'd0, ack_o}, 32'd1);
    check("rd_err", {31'd0, err_o}, 32'd0);
    check("rd_dat", dat_o, 32'h12345678);
    check("rd_cyc", {28'd0, cyc_o}, 32'h2);
    tick();
    drop();
    #1;
    check("rd_done_ack", {31'd0, ack_o}, 32'd0);
    check("rd_done_cyc", {28'd0, cyc_o}, 32'd0);

    // Write id 2 with partial byte selects
    req(30'h0800_0010, 1'b1, 4'b0011, 32'hCAFEF00D);
    #1;
    check("wr_bc_we",  {31'd0, swe_o}, 32'd1);
    check("wr_bc_sel", {28'd0, ssel_o}, 32'h3);
    check("wr_bc_adr", {2'd0, sadr_o}, 32'h0800_0010);
    check("wr_bc_dat", sdat_o, 32'hCAFEF00D);
    check("wr_idle_cyc", {28'd0, cyc_o}, 32'd0);
    tick();
    s_ack[2] = 1'b1;
    #1;
    check("wr_cyc", {28'd0, cyc_o}, 32'h4);
    check("wr_stb", {28'd0, stb_o}, 32'h4);
    check("wr_ack", {31'd0, ack_o}, 32'd1);
    tick();
    drop();

    // Unmapped id F: err on one instance, ack with filler data on the other
    req(30'h3C00_0000, 1'b0, 4'hF, 32'h0);
    #1;
    check("um_req_err", {31'd0, err_o}, 32'd0);
    tick(); #1;
    check("um_err",    {31'd0, err_o}, 32'd1);
    check("um_ack",    {31'd0, ack_o}, 32'd0);
    check("um_cyc",    {28'd0, cyc_o}, 32'd0);
    check("uma_ack",   {31'd0, a_ack_o}, 32'd1);
    check("uma_err",   {31'd0, a_err_o}, 32'd0);
    check("uma_dat",   a_dat_o, 32'hDEADBEEF);
    tick();
    drop();
    #1;
    check("um_err_off", {31'd0, err_o}, 32'd0);

    // id 4 is not in the table either
    req(30'h1000_0004, 1'b0, 4'hF, 32'h0);
    tick(); #1;
    check("um4_err", {31'd0, err_o}, 32'd1);
    check("um4_cyc", {28'd0, cyc_o}, 32'd0);
    tick();
    drop();

    // Watchdog: slave 0 never answers, error on the 8th ACTIVE cycle
    req(30'h0000_0040, 1'b0, 4'hF, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      tick(); #1;
      check($sformatf("wd_c%0d_err", c), {31'd0, err_o}, 32'd0);
      check($sformatf("wd_c%0d_cyc", c), {28'd0, cyc_o}, 32'h1);
    end
    tick(); #1;
    check("wd_fire_err", {31'd0, err_o}, 32'd1);
    check("wd_fire_ack", {31'd0, ack_o}, 32'd0);
    check("wd_fire_cyc", {28'd0, cyc_o}, 32'd0);
    tick();
    drop();
    #1;
    check("wd_after_err", {31'd0, err_o}, 32'd0);
    check("wd_after_cyc", {28'd0, cyc_o}, 32'd0);
    req(30'h0400_0000, 1'b0, 4'hF, 32'h0);
    tick();
    s_ack[1] = 1'b1;
    #1;
    check("wd_next_cyc", {28'd0, cyc_o}, 32'h2);
    check("wd_next_ack", {31'd0, ack_o}, 32'd1);
    check("wd_next_dat", dat_o, 32'h12345678);
    tick();
    drop();

    // Master abandons mid-ACTIVE; late slave ack must not reach the master
    req(30'h0400_0008, 1'b0, 4'hF, 32'h0);
    tick();
    tick();
    m_cyc = 1'b0;
    m_stb = 1'b0;
    #1;
    check("ab_cyc_drop", {28'd0, cyc_o}, 32'd0);
    tick();
    s_ack[1] = 1'b1;
    #1;
    check("ab_late_ack", {31'd0, ack_o}, 32'd0);
    tick();
    drop();
    req(30'h0800_0000, 1'b0, 4'hF, 32'h0);
    #1;
    check("ab_new_idle", {28'd0, cyc_o}, 32'd0);
    tick();
    s_ack[2] = 1'b1;
    #1;
    check("ab_new_cyc", {28'd0, cyc_o}, 32'h4);
    check("ab_new_ack", {31'd0, ack_o}, 32'd1);
    check("ab_new_dat", dat_o, 32'h22222222);
    tick();
    drop();

    // Asynchronous reset while slave 3 is acking
    req(30'h0C00_0000, 1'b0, 4'hF, 32'h0);
    tick();
    s_ack[3] = 1'b1;
    #1;
    check("ar_pre_ack", {31'd0, ack_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_ack", {31'd0, ack_o}, 32'd0);
    check("ar_err", {31'd0, err_o}, 32'd0);
    check("ar_cyc", {28'd0, cyc_o}, 32'd0);
    check("ar_stb", {28'd0, stb_o}, 32'd0);
    check("ar_dat", dat_o, 32'hDEADBEEF);
    drop();
    tick();
    rst_n = 1'b1;
    tick();
    req(30'h0C00_0004, 1'b0, 4'hF, 32'h0);
    tick();
    s_ack[3] = 1'b1;
    #1;
    check("ar_post_ack", {31'd0, ack_o}, 32'd1);
    check("ar_post_dat", dat_o, 32'h33333333);
    tick();
    drop();

    // Simultaneous ack+err: ack wins; err alone passes through
    req(30'h0400_0000, 1'b0, 4'hF, 32'h0);
    tick();
    s_ack[1] = 1'b1;
    s_err[1] = 1'b1;
    #1;
    check("ae_ack", {31'd0, ack_o}, 32'd1);
    check("ae_err", {31'd0, err_o}, 32'd0);
    tick();
    drop();
    req(30'h0000_0000, 1'b0, 4'hF, 32'h0);
    tick();
    s_err[0] = 1'b1;
    #1;
    check("se_err", {31'd0, err_o}, 32'd1);
    check("se_ack", {31'd0, ack_o}, 32'd0);
    tick();
    drop();
    #1;
    check("se_done", {31'd0, err_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
